// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, bimodal branch predictor (2-bit counters),
// and the registered fetch/decode boundary latch.
module fetch_stage #(
    parameter int          BHT_IDX_BITS = 4,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [1:0]  BHT_INIT     = 2'b01
) (
    input  logic        stg_clk,
    input  logic        reset,
    input  logic        stg_ena,
    input  logic        stg_x,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        valid_out,
    output logic        branch_prediction_out,
    output logic [1:0]  counter_out
);

    localparam int BHT_SIZE = 1 << BHT_IDX_BITS;

    logic [31:0]             pc_r;
    logic [1:0]              bht_r [BHT_SIZE];
    logic [BHT_IDX_BITS-1:0] idx_s;
    logic [BHT_IDX_BITS-1:0] uidx_s;
    logic [1:0]              cnt_s;
    logic                    is_br_s;
    logic                    pred_s;
    logic [31:0]             bimm_s;
    logic [31:0]             pc_nxt_s;
    logic                    unused_s;

    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (cnt == 2'b11) res = cnt;
            else              res = cnt + 2'b01;
        end else begin
            if (cnt == 2'b00) res = cnt;
            else              res = cnt - 2'b01;
        end
        return res;
    endfunction

    assign instr_addr = pc_r;
    assign idx_s      = pc_r[BHT_IDX_BITS+1:2];
    assign uidx_s     = upd_pc[BHT_IDX_BITS+1:2];
    // Counter read comes from registered state, so a same-edge update is seen only next cycle.
    assign cnt_s      = bht_r[idx_s];
    assign is_br_s    = (instr_data[6:0] == 7'b1100011);
    assign pred_s     = is_br_s & cnt_s[1];
    assign bimm_s     = {{19{instr_data[31]}}, instr_data[31], instr_data[7],
                         instr_data[30:25], instr_data[11:8], 1'b0};
    assign unused_s   = ^{upd_pc[31:BHT_IDX_BITS+2], upd_pc[1:0], redirect_pc[1:0]};

    // Next-PC selection: redirect beats advance, otherwise hold.
    always_comb begin
        pc_nxt_s = pc_r;
        if (stg_x) begin
            pc_nxt_s = {redirect_pc[31:2], 2'b00};
        end else if (stg_ena) begin
            if (pred_s) pc_nxt_s = pc_r + bimm_s;
            else        pc_nxt_s = pc_r + 32'd4;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // PC register.
    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) pc_r <= RESET_PC;
        else        pc_r <= pc_nxt_s;
    end

    // Branch history table; updates ignore stall and flush.
    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BHT_SIZE; i++) bht_r[i] <= BHT_INIT;
        end else if (upd_en) begin
            bht_r[uidx_s] <= sat_next(bht_r[uidx_s], upd_taken);
        end
    end

    // Fetch/decode boundary latch: flush inserts a bubble, stall holds.
    always_ff @(posedge stg_clk or negedge reset) begin
        if (!reset) begin
            pc_out                <= 32'h0000_0000;
            instr_out             <= 32'h0000_0000;
            valid_out             <= 1'b0;
            branch_prediction_out <= 1'b0;
            counter_out           <= 2'b00;
        end else if (stg_x) begin
            pc_out                <= 32'h0000_0000;
            instr_out             <= 32'h0000_0000;
            valid_out             <= 1'b0;
            branch_prediction_out <= 1'b0;
            counter_out           <= 2'b00;
        end else if (stg_ena) begin
            pc_out                <= pc_r;
            instr_out             <= instr_data;
            valid_out             <= 1'b1;
            branch_prediction_out <= pred_s;
            counter_out           <= cnt_s;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32 core. Sits directly upstream of the decode stage and feeds it.
- Holds the PC and drives the instruction-memory address.
- Predicts conditional branches with a table of 2-bit saturating counters indexed by PC.
- Registers pc, instruction, valid, branch_prediction and counter into the fetch/decode boundary. The decode stage carries the prediction and counter forward for resolution in execute.

Parameters:
- BHT_IDX_BITS, 4, log2 of branch-history-table entries (16 entries).
- RESET_PC, 32'h0000_0000, PC loaded at reset.
- BHT_INIT, 2'b01, counter value loaded into every entry at reset (weakly not-taken).

Ports:
- stg_clk  in  1  stage clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- stg_ena  in  1  advance enable; 0 = stall (hold PC and output latch).
- stg_x  in  1  flush/redirect from execute (mispredict or jump).
- redirect_pc  in  32  new PC, used when stg_x=1.
- instr_addr  out  32  instruction-memory byte address (combinational, = PC register).
- instr_data  in  32  instruction word; combinational read, valid in the same cycle as instr_addr.
- upd_en  in  1  branch-history update strobe from execute.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- pc_out  out  32  PC of the latched instruction.
- instr_out  out  32  latched instruction word.
- valid_out  out  1  latched instruction is real (not a bubble).
- branch_prediction_out  out  1  1 = fetch predicted taken.
- counter_out  out  2  BHT counter value used for the prediction.

Behaviour:
- Reset (reset=0, asynchronous, any time, including mid-stall or mid-update):
  - PC register = RESET_PC.
  - All BHT entries = BHT_INIT.
  - pc_out, instr_out, counter_out = 0; valid_out = 0; branch_prediction_out = 0.
- instr_addr = PC register, combinational.
- Prediction (combinational, current cycle):
  - idx = PC[BHT_IDX_BITS+1:2]; cnt = bht[idx].
  - is_br = (instr_data[6:0] == 7'b1100011).
  - pred = is_br & cnt[1].
  - bimm = sign-extended {instr_data[31], instr_data[7], instr_data[30:25], instr_data[11:8], 1'b0}.
- Next PC, priority order:
  - stg_x=1: PC <= {redirect_pc[31:2], 2'b00}. Low bits are forced to 0.
  - else stg_ena=1: PC <= pred ? PC + bimm : PC + 4. 32-bit modulo; wrap-around is legal.
  - else: PC held.
- Output latch, same priority:
  - stg_x=1: all outputs cleared to 0 (bubble, valid_out=0), regardless of stg_ena.
  - else stg_ena=1: pc_out <= PC, instr_out <= instr_data, valid_out <= 1, branch_prediction_out <= pred, counter_out <= cnt.
  - else: all outputs held.
- Latency: an instruction at PC appears on the outputs 1 cycle after the edge where stg_ena=1 and stg_x=0. The first valid output is one edge after reset release with stg_ena=1.
- BHT update on upd_en=1 at the edge:
  - uidx = upd_pc[BHT_IDX_BITS+1:2].
  - taken: counter +1, saturating at 2'b11. Not taken: counter -1, saturating at 2'b00.
  - Independent of stg_ena and stg_x; updates still occur during stall and flush.
- Same-cycle update and prediction to the same index: the prediction and counter_out use the pre-update value. The new value is visible from the next cycle.
- Non-branch instructions always produce pred=0. counter_out still reports cnt for them.
- Only one update per cycle.

Test Plan:
- Reset and sequential fetch:
  - Stimulus: reset low then high; stg_ena=1 for 3 cycles; memory returns ADDI at 0, 4, 8.
  - Required: pc_out = 0, 4, 8; valid_out=1 from the first edge; counter_out=2'b01; branch_prediction_out=0.
- Stall:
  - Stimulus: stg_ena=0 for 2 cycles at PC=8.
  - Required: instr_addr stays 8; all outputs unchanged; then resumes with pc_out=8 on the next enabled edge.
- Predicted-taken branch:
  - Stimulus: 2 upd_en taken updates for upd_pc=0x10, taking entry 4 from 01 to 11; fetch BEQ at 0x10 with imm=+0x20.
  - Required: branch_prediction_out=1; counter_out=2'b11; next instr_addr=0x30.
- Saturation:
  - Stimulus: 3 not-taken updates on an entry at 01.
  - Required: counter reads 00, never wraps to 11.
  - Stimulus: 3 taken updates on 11.
  - Required: stays 11.
- Flush priority:
  - Stimulus: stg_x=1 and stg_ena=1 in the same cycle, redirect_pc=0x103.
  - Required: outputs cleared with valid_out=0; instr_addr=0x100; the next enabled edge gives pc_out=0x100.
- Async reset mid-operation:
  - Stimulus: reset low between clock edges while valid_out=1 and an entry is at 11.
  - Required: outputs clear immediately, without a clock edge; instr_addr=RESET_PC; after release, that entry reads 01.
